load_activate: RTL and testbench

Activation window loader that sits directly downstream of the core/load sequencer. On each `start_load` pulse it fetches the next K×K convolution window of a single-channel activation map from on-chip activation memory into a staging buffer, then raises `activate_ready`. On the following `start_load` it hands the staged window to the compute core through a stable shadow register, so the core computes on one window while the next is fetched.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/act_window_addr_gen.sv | 90 +++++++++
 rtl/load_activate.sv | 151 +++++++++++++++
 tb/tb_load_activate.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants and the load_activate state encoding.
package cnn_pkg;

  localparam int CNN_K     = 3;
  localparam int CNN_IMG_W = 28;
  localparam int CNN_IMG_H = 28;

  typedef enum logic [1:0] {
    LA_EMPTY = 2'd0,
    LA_FETCH = 2'd1,
    LA_DRAIN = 2'd2,
    LA_READY = 2'd3
  } la_state_e;

endpackage

// File: rtl/act_window_addr_gen.sv
// Window position (row/col) and in-window (i/j) counters plus the
// activation memory address multiply-add; the address is registered.
module act_window_addr_gen
  import cnn_pkg::*;
#(
  parameter int K      = CNN_K,
  parameter int IMG_W  = CNN_IMG_W,
  parameter int IMG_H  = CNN_IMG_H,
  parameter int ADDR_W = 16,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [15:0]       row_o,
  output logic [15:0]       col_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [15:0]       row_q, row_d, col_q, col_d, i_q, i_d, j_q, j_d;
  logic [31:0]       lin_s;

  // Next counter values and the address of the element they select.
  always_comb begin
    base_d = base_q;
    row_d  = row_q;
    col_d  = col_q;
    i_d    = i_q;
    j_d    = j_q;
    if (load_i) begin
      base_d = base_i;
      i_d    = 16'd0;
      j_d    = 16'd0;
      if (adv_i) begin
        if (col_q == 16'(IMG_W - K)) begin
          col_d = 16'd0;
          row_d = (row_q == 16'(IMG_H - K)) ? 16'd0 : row_q + 16'd1;
        end else begin
          col_d = col_q + 16'd1;
        end
      end else begin
        row_d = row_q;
      end
    end else if (step_i) begin
      if (j_q == 16'(K - 1)) begin
        j_d = 16'd0;
        i_d = i_q + 16'd1;
      end else begin
        j_d = j_q + 16'd1;
      end
    end else begin
      i_d = i_q;
    end
    // Wraps modulo 2^ADDR_W by truncation.
    lin_s  = (32'(row_d) + 32'(i_d)) * 32'(IMG_W) + 32'(col_d) + 32'(j_d);
    addr_d = base_d + lin_s[ADDR_W-1:0];
  end

  // Counter and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      addr_q <= '0;
      row_q  <= 16'd0;
      col_q  <= 16'd0;
      i_q    <= 16'd0;
      j_q    <= 16'd0;
    end else begin
      base_q <= base_d;
      addr_q <= addr_d;
      row_q  <= row_d;
      col_q  <= col_d;
      i_q    <= i_d;
      j_q    <= j_d;
    end
  end

  assign addr_o = addr_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign slot_o = SLOT_W'(32'(i_q) * 32'(K) + 32'(j_q));
  assign last_o = (i_q == 16'(K - 1)) && (j_q == 16'(K - 1));

endmodule

// File: rtl/load_activate.sv
// Activation window loader: FSM, staging buffer and handover shadow register.
// Define LOAD_ACTIVATE_OVERRUN_CHK_EN to add the sticky overrun_err output.
module load_activate
  import cnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = CNN_K,
  parameter int IMG_W  = CNN_IMG_W,
  parameter int IMG_H  = CNN_IMG_H,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  activate_ready,
  output logic [K*K*DATA_W-1:0] act_out,
  output logic [15:0]           act_row,
  output logic [15:0]           act_col,
  output logic                  frame_done
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
  ,output logic                 overrun_err
`endif
);

  localparam int NW     = K * K;
  localparam int SLOT_W = (NW > 1) ? $clog2(NW) : 1;

  la_state_e             state_q;
  logic                  mem_en_q, ready_q, frame_done_q, rd_pend_q;
  logic [SLOT_W-1:0]     rd_slot_q, slot_s;
  logic [DATA_W-1:0]     stg_q [NW];
  logic [NW*DATA_W-1:0]  act_q;
  logic [15:0]           act_row_q, act_col_q, gen_row_s, gen_col_s;
  logic                  accept_s, step_s, last_s;

  assign accept_s = start_load && ((state_q == LA_EMPTY) || (state_q == LA_READY));
  assign step_s   = (state_q == LA_FETCH) && !last_s;

  act_window_addr_gen #(
    .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .SLOT_W(SLOT_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept_s),
    .adv_i  (state_q == LA_READY),
    .step_i (step_s),
    .base_i (base_addr),
    .addr_o (mem_addr),
    .row_o  (gen_row_s),
    .col_o  (gen_col_s),
    .slot_o (slot_s),
    .last_o (last_s)
  );

  // Control FSM with registered enable, ready, frame pulse and handover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LA_EMPTY;
      mem_en_q     <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      act_q        <= '0;
      act_row_q    <= 16'd0;
      act_col_q    <= 16'd0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        LA_EMPTY: begin
          if (start_load) begin
            state_q  <= LA_FETCH;
            mem_en_q <= 1'b1;
          end
        end
        LA_FETCH: begin
          if (last_s) begin
            state_q  <= LA_DRAIN;
            mem_en_q <= 1'b0;
          end
        end
        LA_DRAIN: begin
          state_q      <= LA_READY;
          ready_q      <= 1'b1;
          frame_done_q <= (gen_row_s == 16'(IMG_H - K)) && (gen_col_s == 16'(IMG_W - K));
        end
        LA_READY: begin
          if (start_load) begin
            state_q   <= LA_FETCH;
            mem_en_q  <= 1'b1;
            ready_q   <= 1'b0;
            act_row_q <= gen_row_s;
            act_col_q <= gen_col_s;
            for (int s = 0; s < NW; s++) begin
              act_q[s*DATA_W +: DATA_W] <= stg_q[s];
            end
          end
        end
        default: begin
          state_q  <= LA_EMPTY;
          mem_en_q <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read data lands in its slot one cycle after the read was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_slot_q <= '0;
      for (int s = 0; s < NW; s++) begin
        stg_q[s] <= '0;
      end
    end else begin
      rd_pend_q <= mem_en_q;
      rd_slot_q <= slot_s;
      if (rd_pend_q) begin
        stg_q[rd_slot_q] <= mem_rdata;
      end
    end
  end

`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
  logic overrun_q;

  // Sticky flag for start pulses that arrive while a fetch is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (start_load && ((state_q == LA_FETCH) || (state_q == LA_DRAIN))) begin
      overrun_q <= 1'b1;
    end else begin
      overrun_q <= overrun_q;
    end
  end

  assign overrun_err = overrun_q;
`endif

  assign mem_en         = mem_en_q;
  assign activate_ready = ready_q;
  assign act_out        = act_q;
  assign act_row        = act_row_q;
  assign act_col        = act_col_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_load_activate.sv
// Self-checking bench for load_activate on a 5x5 map with K=3.
module tb_load_activate;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int AW = 16;
  localparam int NW = K * K;
  localparam int NC = W - K + 1;
  localparam int NR = H - K + 1;
  localparam int NWIN = NC * NR;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_load;
  logic [AW-1:0]     base_addr;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic              activate_ready;
  logic [NW*DW-1:0]  act_out;
  logic [15:0]       act_row, act_col;
  logic              frame_done;
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
  logic              overrun_err;
  bit                m_ovr;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          start;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic          exp_rdy;
  } vec_t;

  vec_t tbl [12];

  int               m_next;
  logic [AW-1:0]    m_base;
  bit               m_staged;
  int               m_staged_n;
  logic [NW*DW-1:0] m_act;
  logic [15:0]      m_row, m_col;

  always #5 clk = ~clk;

  load_activate #(.DATA_W(DW), .K(K), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .base_addr(base_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .activate_ready(activate_ready), .act_out(act_out),
    .act_row(act_row), .act_col(act_col), .frame_done(frame_done)
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
    , .overrun_err(overrun_err)
`endif
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_word(mem_addr);
  end

  function automatic int pos_r(input int n); return n / NC; endfunction
  function automatic int pos_c(input int n); return n % NC; endfunction

  function automatic logic [AW-1:0] win_addr(input int n, input logic [AW-1:0] b, input int e);
    logic [31:0] s;
    s = 32'(b) + 32'((pos_r(n) + e / K) * W + pos_c(n) + e % K);
    return s[AW-1:0];
  endfunction

  function automatic logic [NW*DW-1:0] win_data(input int n, input logic [AW-1:0] b);
    logic [NW*DW-1:0] v;
    for (int e = 0; e < NW; e++) v[e*DW +: DW] = mem_word(win_addr(n, b, e));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_ready"}, activate_ready, 0);
    chk({tag, "_act_out"}, act_out, 0);
    chk({tag, "_act_row"}, act_row, 0);
    chk({tag, "_act_col"}, act_col, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
    chk({tag, "_overrun"}, overrun_err, 0);
`endif
  endtask

  // Asserts reset from wherever we are, checks outputs clear immediately.
  task automatic do_reset(input logic [AW-1:0] b);
    rst = 1'b1;
    start_load = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    base_addr = b;
    m_next = 0; m_base = b; m_staged = 0; m_staged_n = 0;
    m_act = '0; m_row = 16'd0; m_col = 16'd0;
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
    m_ovr = 0;
`endif
  endtask

  // Applies the fixed first-window table (base 0, window (0,0)).
  task automatic run_table();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("tbl_mem_en", mem_en, tbl[k].exp_en);
        if (tbl[k].exp_en) chk("tbl_mem_addr", mem_addr, tbl[k].exp_addr);
        chk("tbl_ready", activate_ready, tbl[k].exp_rdy);
        chk("tbl_act_out", act_out, m_act);
      end
      start_load = tbl[k].start;
    end
    start_load = 1'b0;
    m_staged = 1; m_staged_n = 0; m_next = 1;
  endtask

  task automatic load_window(input int glitch, input int gap);
    logic [NW*DW-1:0] exp_act;
    logic [15:0]      exp_row, exp_col;
    int n;
    n = m_next;
    exp_act = m_act; exp_row = m_row; exp_col = m_col;
    if (m_staged) begin
      exp_act = win_data(m_staged_n, m_base);
      exp_row = 16'(pos_r(m_staged_n));
      exp_col = 16'(pos_c(m_staged_n));
    end
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
    if (glitch >= 1 && glitch <= 10) m_ovr = 1;
`endif
    @(negedge clk);
    base_addr = m_base;
    start_load = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_load = (k == glitch);
      base_addr = AW'($urandom);
      if (k <= 9) begin
        chk("mem_en_fetch", mem_en, 1);
        chk("mem_addr", mem_addr, win_addr(n, m_base, k - 1));
      end else begin
        chk("mem_en_idle", mem_en, 0);
      end
      chk("ready", activate_ready, (k == 11));
      chk("frame_done", frame_done, (k == 11) && (n == NWIN - 1));
      chk("act_out", act_out, exp_act);
      chk("act_row", act_row, exp_row);
      chk("act_col", act_col, exp_col);
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
      if (k == 11) chk("overrun_err", overrun_err, m_ovr);
`endif
    end
    start_load = 1'b0;
    m_staged = 1; m_staged_n = n; m_act = exp_act; m_row = exp_row; m_col = exp_col;
    m_next = (n + 1) % NWIN;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("gap_ready", activate_ready, 1);
      chk("gap_mem_en", mem_en, 0);
      chk("gap_frame_done", frame_done, 0);
      chk("gap_act_out", act_out, m_act);
    end
  endtask

  initial begin
    logic [AW-1:0] addrs [9];
    addrs = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd7, 16'd10, 16'd11, 16'd12};
    tbl[0] = '{start: 1'b1, exp_en: 1'b0, exp_addr: 16'd0, exp_rdy: 1'b0};
    for (int k = 1; k <= 9; k++)
      tbl[k] = '{start: 1'b0, exp_en: 1'b1, exp_addr: addrs[k-1], exp_rdy: 1'b0};
    tbl[10] = '{start: 1'b0, exp_en: 1'b0, exp_addr: 16'd0, exp_rdy: 1'b0};
    tbl[11] = '{start: 1'b0, exp_en: 1'b0, exp_addr: 16'd0, exp_rdy: 1'b1};

    start_load = 1'b0;
    base_addr = '0;
    #2;
    do_reset(16'h0000);

    // First window from the table, then a full frame plus the wrap to (0,0).
    run_table();
    for (int w = 1; w <= NWIN; w++) load_window(0, $urandom_range(0, 2));

    // Reset in the middle of a fetch (cycle C+5).
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    repeat (4) @(negedge clk);
    do_reset(16'h0000);
    load_window(0, 1);

    // Address arithmetic wraps modulo 2^16.
    do_reset(16'hFFFE);
    load_window(0, 1);
    load_window(0, 0);

    // Start pulse during FETCH is ignored; table timing must be unchanged.
    do_reset(16'h0000);
    tbl[4].start = 1'b1;
    run_table();
`ifdef LOAD_ACTIVATE_OVERRUN_CHK_EN
    m_ovr = 1;
    chk("tbl_overrun", overrun_err, 1);
`endif
    load_window(0, 0);

    // Randomized base, gaps and ignored pulses.
    do_reset(AW'($urandom));
    for (int r = 0; r < 25; r++)
      load_window(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0,
                  $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
